// File: rtl/ide_pkg.sv
// ide_pkg: shared definitions for the IDE PIO cycle engine.
//   state_t            : engine states (IDLE, LOAD, SETUP, ACTIVE, RECOVER, DONE)
//   CS_IDLE / DA_IDLE  : values parked on ide_cs / ide_da when no cycle is in flight
//   addr_cs / addr_da  : split a 5-bit register address into chip-select and address fields
package ide_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SETUP   = 3'd2,
    ACTIVE  = 3'd3,
    RECOVER = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] CS_IDLE = 2'b11;
  localparam logic [2:0] DA_IDLE = 3'b111;

  localparam int CS_HI = 4;
  localparam int CS_LO = 3;
  localparam int DA_HI = 2;
  localparam int DA_LO = 0;

  function automatic logic [1:0] addr_cs(input logic [4:0] addr);
    return addr[CS_HI:CS_LO];
  endfunction

  function automatic logic [2:0] addr_da(input logic [4:0] addr);
    return addr[DA_HI:DA_LO];
  endfunction

endpackage

// File: rtl/ide_pio_ctl_if.sv
// ide_pio_ctl_if: host-side request / stream bundle of the IDE PIO engine.
//   req_*      : request handshake plus request fields (wr, addr, count)
//   cfg_*      : per-phase lengths minus one, sampled when a request is accepted
//   wdata_*    : write-data stream into the engine (valid/ready)
//   rdata_*    : read-data stream out of the engine (1-cycle strobe, no backpressure)
//   busy, done : engine status
// Modports: master = register logic side, slave = ide_pio_ctl.
interface ide_pio_ctl_if #(
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 4,
  parameter int BURST_W = 9
);
  logic               req_valid;
  logic               req_ready;
  logic               req_wr;
  logic [4:0]         req_addr;
  logic [BURST_W-1:0] req_count;
  logic [CNT_W-1:0]   cfg_setup;
  logic [CNT_W-1:0]   cfg_active;
  logic [CNT_W-1:0]   cfg_recover;
  logic [DATA_W-1:0]  wdata;
  logic               wdata_valid;
  logic               wdata_ready;
  logic [DATA_W-1:0]  rdata;
  logic               rdata_valid;
  logic               busy;
  logic               done;

  modport master (
    output req_valid, req_wr, req_addr, req_count,
    output cfg_setup, cfg_active, cfg_recover,
    output wdata, wdata_valid,
    input  req_ready, wdata_ready, rdata, rdata_valid, busy, done
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_count,
    input  cfg_setup, cfg_active, cfg_recover,
    input  wdata, wdata_valid,
    output req_ready, wdata_ready, rdata, rdata_valid, busy, done
  );
endinterface

// File: rtl/ide_iordy_sync.sv
// ide_iordy_sync: two-flop synchronizer for the asynchronous IDE IORDY pin.
//   clk, reset : clock, asynchronous active-high reset (output resets to 1 = ready)
//   d          : raw ide_iordy
//   q          : synchronized iordy
module ide_iordy_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;
endmodule

// File: rtl/ide_pio_ctl.sv
// ide_pio_ctl: IDE/ATA PIO cycle engine (single word or multi-word burst).
//   clk, reset   : clock, asynchronous active-high reset
//   host         : ide_pio_ctl_if.slave (request, cfg, write/read streams, busy/done)
//   ide_data_bus : IDE data pins (driven only for writes, SETUP..RECOVER)
//   ide_dior/ide_diow : active-low read/write strobes
//   ide_cs/ide_da     : chip selects / register address
//   ide_iordy    : device ready; used only when IDE_IORDY_EN is defined, which
//                  adds a 2-flop synchronizer and stretches ACTIVE while it is low.
module ide_pio_ctl
  import ide_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 4,
  parameter int BURST_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  ide_pio_ctl_if.slave      host,
  inout  wire  [DATA_W-1:0] ide_data_bus,
  output logic              ide_dior,
  output logic              ide_diow,
  output logic [1:0]        ide_cs,
  output logic [2:0]        ide_da,
  input  logic              ide_iordy
);
  localparam int REM_W = BURST_W + 1;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [REM_W-1:0]   rem_reg, rem_next;
  logic               wr_reg;
  logic [4:0]         addr_reg;
  logic [CNT_W-1:0]   setup_reg, active_reg, recover_reg;
  logic [DATA_W-1:0]  wdata_reg, rdata_reg;
  logic               rdata_valid_reg;
  logic               dior_reg, diow_reg, bus_oe_reg;
  logic [1:0]         cs_reg;
  logic [2:0]         da_reg;
  logic               accept, sample, iordy_s;
  logic               wr_d;
  logic [4:0]         addr_d;
  logic               pins_active_next;

`ifdef IDE_IORDY_EN
  ide_iordy_sync u_iordy_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ide_iordy),
    .q     (iordy_s)
  );
`else
  logic unused_iordy;
  assign unused_iordy = ide_iordy;
  assign iordy_s      = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // One phase counter serves SETUP/ACTIVE/RECOVER: it is reloaded with the
  // latched length on entry to each phase and the phase ends when it hits 0.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rem_next   = rem_reg;
    accept     = 1'b0;
    sample     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (host.req_valid) begin
          accept     = 1'b1;
          state_next = LOAD;
          rem_next   = (host.req_count == '0) ? (REM_W'(1) << BURST_W)
                                              : {1'b0, host.req_count};
        end
      end
      LOAD: begin
        if (!wr_reg || host.wdata_valid) begin
          state_next = SETUP;
          cnt_next   = setup_reg;
        end
      end
      SETUP: begin
        if (cnt_reg == '0) begin
          state_next = ACTIVE;
          cnt_next   = active_reg;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (cnt_reg == '0) begin
          // Without the IORDY option iordy_s is tied high.
          if (iordy_s) begin
            state_next = RECOVER;
            cnt_next   = recover_reg;
            sample     = !wr_reg;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      RECOVER: begin
        if (cnt_reg == '0) begin
          rem_next   = rem_reg - REM_W'(1);
          state_next = (rem_reg == REM_W'(1)) ? DONE : LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pin flops are computed from the next state so they line up with state_reg
  // while still coming straight out of registers.
  assign wr_d             = accept ? host.req_wr   : wr_reg;
  assign addr_d           = accept ? host.req_addr : addr_reg;
  assign pins_active_next = state_next inside {LOAD, SETUP, ACTIVE, RECOVER};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg         <= '0;
      rem_reg         <= '0;
      wr_reg          <= 1'b0;
      addr_reg        <= '0;
      setup_reg       <= '0;
      active_reg      <= '0;
      recover_reg     <= '0;
      wdata_reg       <= '0;
      rdata_reg       <= '0;
      rdata_valid_reg <= 1'b0;
      dior_reg        <= 1'b1;
      diow_reg        <= 1'b1;
      cs_reg          <= CS_IDLE;
      da_reg          <= DA_IDLE;
      bus_oe_reg      <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      rem_reg <= rem_next;
      if (accept) begin
        wr_reg      <= host.req_wr;
        addr_reg    <= host.req_addr;
        setup_reg   <= host.cfg_setup;
        active_reg  <= host.cfg_active;
        recover_reg <= host.cfg_recover;
      end
      if (state_reg == LOAD && wr_reg && host.wdata_valid)
        wdata_reg <= host.wdata;
      if (sample)
        rdata_reg <= ide_data_bus;
      rdata_valid_reg <= sample;
      dior_reg   <= !(state_next == ACTIVE && !wr_d);
      diow_reg   <= !(state_next == ACTIVE && wr_d);
      cs_reg     <= pins_active_next ? addr_cs(addr_d) : CS_IDLE;
      da_reg     <= pins_active_next ? addr_da(addr_d) : DA_IDLE;
      // Write data stays on the bus through the strobe's rising edge and recovery.
      bus_oe_reg <= wr_d && (state_next inside {SETUP, ACTIVE, RECOVER});
    end
  end

  assign ide_data_bus     = bus_oe_reg ? wdata_reg : {DATA_W{1'bz}};
  assign ide_dior         = dior_reg;
  assign ide_diow         = diow_reg;
  assign ide_cs           = cs_reg;
  assign ide_da           = da_reg;

  assign host.req_ready   = (state_reg == IDLE);
  assign host.wdata_ready = (state_reg == LOAD) && wr_reg;
  assign host.rdata       = rdata_reg;
  assign host.rdata_valid = rdata_valid_reg;
  assign host.busy        = (state_reg != IDLE);
  assign host.done        = (state_reg == DONE);
endmodule

// File: tb/tb_ide_pio_ctl.sv
// tb_ide_pio_ctl: self-checking bench for ide_pio_ctl (BURST_W=2 so a count of 0
// means 4 words). A vector table drives complete requests; expected read and
// write words are queued at accept and compared as the DUT delivers them.
module tb_ide_pio_ctl;
  localparam int DATA_W  = 16;
  localparam int CNT_W   = 4;
  localparam int BURST_W = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ide_pio_ctl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_W(BURST_W)) host ();

  wire  [DATA_W-1:0] ide_data_bus;
  logic              ide_dior, ide_diow, ide_iordy;
  logic [1:0]        ide_cs;
  logic [2:0]        ide_da;
  logic [DATA_W-1:0] dev_data;

  // Simple device: drives its current word whenever the read strobe is low.
  assign ide_data_bus = ide_dior ? {DATA_W{1'bz}} : dev_data;

  ide_pio_ctl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .host         (host),
    .ide_data_bus (ide_data_bus),
    .ide_dior     (ide_dior),
    .ide_diow     (ide_diow),
    .ide_cs       (ide_cs),
    .ide_da       (ide_da),
    .ide_iordy    (ide_iordy)
  );

  typedef struct {
    logic              wr;
    logic [4:0]        addr;
    logic [BURST_W-1:0] count;
    logic [CNT_W-1:0]  s, a, r;
    logic [DATA_W-1:0] base;
    int                stall_word;
    int                stall_cyc;
    int                words;
    int                exp_done;
  } vec_t;

  vec_t vecs[7];

  int n_vec = 0, n_err = 0;
  int cyc = 0, acc_cyc = 0, acc_cyc_prev = 0, done_cyc = 0;
  int n_acc = 0, n_done = 0;
  int pulses = 0, lo_len = 0, exp_len = 1, first_lo_rel = -1, first_rv_rel = -1;
  int cs_valid_cnt = 0;
  logic [4:0] cur_addr = 5'h0;
  logic prev_dior = 1'b1, prev_diow = 1'b1;
  logic [DATA_W-1:0] wr_cap = '0;
  logic [DATA_W-1:0] next_base = '0;
  logic [DATA_W-1:0] rd_q[$];
  logic [DATA_W-1:0] wr_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observes the current cycle (called at the falling edge).
  task automatic monitor();
    int nw;
    if (host.req_valid && host.req_ready) begin
      acc_cyc_prev = acc_cyc;
      acc_cyc      = cyc;
      n_acc++;
      cur_addr = host.req_addr;
      exp_len  = int'(host.cfg_active) + 1;
      nw = (host.req_count == '0) ? (1 << BURST_W) : int'(host.req_count);
      for (int i = 0; i < nw; i++) begin
        if (host.req_wr) wr_q.push_back(next_base + DATA_W'(i));
        else             rd_q.push_back(next_base + DATA_W'(i));
      end
      dev_data     = next_base;
      pulses       = 0;
      first_lo_rel = -1;
      first_rv_rel = -1;
      cs_valid_cnt = 0;
    end
    if (host.rdata_valid) begin
      if (first_rv_rel < 0) first_rv_rel = cyc - acc_cyc;
      if (rd_q.size() == 0) check("rdata_unexpected", 1, 0);
      else                  check("rdata", int'(host.rdata), int'(rd_q.pop_front()));
    end
    if (!ide_dior || !ide_diow) begin
      lo_len++;
      if (first_lo_rel < 0) first_lo_rel = cyc - acc_cyc;
      if (!ide_diow) wr_cap = ide_data_bus;
    end
    if ((ide_dior && !prev_dior) || (ide_diow && !prev_diow)) begin
      pulses++;
      check("strobe_len", lo_len, exp_len);
      lo_len = 0;
      if (!prev_dior) dev_data = dev_data + DATA_W'(1);
      if (!prev_diow) begin
        if (wr_q.size() == 0) check("wdata_unexpected", 1, 0);
        else                  check("bus_wdata", int'(wr_cap), int'(wr_q.pop_front()));
      end
    end
    prev_dior = ide_dior;
    prev_diow = ide_diow;
    if (ide_cs == cur_addr[4:3] && ide_da == cur_addr[2:0]) cs_valid_cnt++;
    if (host.done) begin
      done_cyc = cyc;
      n_done++;
    end
  endtask

  task automatic tick();
    monitor();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive_req(input vec_t v);
    next_base        = v.base;
    host.req_wr      = v.wr;
    host.req_addr    = v.addr;
    host.req_count   = v.count;
    host.cfg_setup   = v.s;
    host.cfg_active  = v.a;
    host.cfg_recover = v.r;
    host.req_valid   = 1'b1;
  endtask

  task automatic wait_accept(input int acc0);
    int guard = 0;
    while (n_acc == acc0 && guard < 50) begin
      tick();
      guard++;
    end
    check("accept", n_acc - acc0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int widx, stall_left, guard, d0;
    bit hs;
    drive_req(v);
    wait_accept(n_acc);
    host.req_valid = 1'b0;
    widx = 0;
    stall_left = v.stall_cyc;
    d0 = n_done;
    guard = 0;
    while (n_done == d0 && guard < 200) begin
      if (v.wr) begin
        if (widx == v.stall_word && stall_left > 0) begin
          host.wdata_valid = 1'b0;
          if (host.wdata_ready) stall_left--;
        end else begin
          host.wdata_valid = (widx < v.words);
          host.wdata       = v.base + DATA_W'(widx);
        end
      end
      hs = host.wdata_valid && host.wdata_ready;
      tick();
      if (hs) widx++;
      guard++;
    end
    host.wdata_valid = 1'b0;
    check("done_cycle", done_cyc - acc_cyc, v.exp_done);
    check("strobe_pulses", pulses, v.words);
    check("first_strobe_rel", first_lo_rel, int'(v.s) + 3);
    check("cs_da_valid_cycles", cs_valid_cnt, v.exp_done - 1);
    if (!v.wr) check("first_rvalid_rel", first_rv_rel, int'(v.s) + int'(v.a) + 4);
    check("queues_drained", rd_q.size() + wr_q.size(), 0);
    check("idle_after_done", {host.busy, host.req_ready, ide_cs}, {1'b0, 1'b1, 2'b11});
  endtask

  initial begin
    int guard, a0, d0, widx;
    bit hs;

    // wr, addr, count, S, A, R, base, stall_word, stall_cyc, words, done cycle
    vecs[0] = '{1'b0, 5'h16, 2'd1, 4'd1, 4'd3, 4'd2, 16'hA55A, -1, 0, 1, 11};
    vecs[1] = '{1'b1, 5'h08, 2'd3, 4'd0, 4'd0, 4'd0, 16'h0001,  1, 2, 3, 15};
    vecs[2] = '{1'b0, 5'h10, 2'd0, 4'd0, 4'd0, 4'd0, 16'h0100, -1, 0, 4, 17};
    vecs[3] = '{1'b0, 5'h0B, 2'd2, 4'd2, 4'd0, 4'd1, 16'h1234, -1, 0, 2, 15};
    vecs[4] = '{1'b1, 5'h15, 2'd2, 4'd0, 4'd2, 4'd3, 16'hBEEF, -1, 0, 2, 19};
    vecs[5] = '{1'b0, 5'h09, 2'd3, 4'd0, 4'd1, 4'd0, 16'h7000, -1, 0, 3, 16};
    vecs[6] = '{1'b1, 5'h12, 2'd1, 4'd3, 4'd0, 4'd0, 16'h0F0F, -1, 0, 1,  8};

    host.req_valid   = 1'b0;
    host.req_wr      = 1'b0;
    host.req_addr    = '0;
    host.req_count   = '0;
    host.cfg_setup   = '0;
    host.cfg_active  = '0;
    host.cfg_recover = '0;
    host.wdata       = '0;
    host.wdata_valid = 1'b0;
    dev_data         = '0;
`ifdef IDE_IORDY_EN
    ide_iordy = 1'b1;
`else
    ide_iordy = 1'b0;  // must be ignored in this build
`endif

    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_dior", ide_dior, 1);
    check("rst_diow", ide_diow, 1);
    check("rst_cs", ide_cs, 3);
    check("rst_da", ide_da, 7);
    check("rst_bus_oe", dut.bus_oe_reg, 0);
    check("rst_wdata_ready", host.wdata_ready, 0);
    check("rst_rdata", int'(host.rdata), 0);
    check("rst_rdata_valid", host.rdata_valid, 0);
    check("rst_busy", host.busy, 0);
    check("rst_done", host.done, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", host.req_ready, 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset during ACTIVE of word 2 of a write burst.
    drive_req('{1'b1, 5'h0D, 2'd3, 4'd0, 4'd3, 4'd0, 16'hC000, -1, 0, 3, 0});
    wait_accept(n_acc);
    host.req_valid = 1'b0;
    widx = 0;
    guard = 0;
    while (!(pulses == 1 && !ide_diow) && guard < 100) begin
      host.wdata_valid = 1'b1;
      host.wdata       = 16'hC000 + DATA_W'(widx);
      hs = host.wdata_ready;
      tick();
      if (hs) widx++;
      guard++;
    end
    check("reached_word2_active", {pulses[1:0], ide_diow}, {2'd1, 1'b0});
    host.wdata_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_strobes", {ide_dior, ide_diow}, 2'b11);
    check("midrst_cs", ide_cs, 3);
    check("midrst_da", ide_da, 7);
    check("midrst_bus_oe", dut.bus_oe_reg, 0);
    check("midrst_busy", host.busy, 0);
    rd_q.delete();
    wr_q.delete();
    prev_dior = 1'b1;
    prev_diow = 1'b1;
    lo_len    = 0;
    d0 = n_done;
    @(negedge clk);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("no_done_after_reset", n_done - d0, 0);
    run_vec(vecs[0]);

    // req_valid held through a busy burst, cfg changed mid-burst.
    a0 = n_acc;
    drive_req('{1'b0, 5'h11, 2'd2, 4'd0, 4'd0, 4'd0, 16'h3000, -1, 0, 2, 9});
    wait_accept(a0);
    host.cfg_setup   = 4'd3;
    host.cfg_active  = 4'd3;
    host.cfg_recover = 4'd3;
    guard = 0;
    while (n_acc == a0 + 1 && guard < 100) begin
      tick();
      guard++;
    end
    check("second_accept", n_acc - a0, 2);
    check("held_done_cycle", done_cyc - acc_cyc_prev, 9);
    check("reaccept_after_done", acc_cyc - done_cyc, 1);
    host.req_valid = 1'b0;
    d0 = n_done;
    guard = 0;
    while (n_done == d0 && guard < 200) begin
      tick();
      guard++;
    end
    check("new_cfg_done_cycle", done_cyc - acc_cyc, 27);
    check("held_queues_drained", rd_q.size(), 0);

`ifdef IDE_IORDY_EN
    // Read with A=1 while iordy is low for 5 cycles across ACTIVE.
    drive_req('{1'b0, 5'h0E, 2'd1, 4'd0, 4'd1, 4'd0, 16'h2222, -1, 0, 1, 0});
    wait_accept(n_acc);
    host.req_valid = 1'b0;
    dev_data = 16'h1111;
    exp_len  = 7;
    d0 = n_done;
    guard = 0;
    while (n_done == d0 && guard < 100) begin
      if (cyc - acc_cyc == 2) ide_iordy = 1'b0;
      if (cyc - acc_cyc == 7) ide_iordy = 1'b1;
      if (cyc - acc_cyc == 9) dev_data = 16'h2222;
      tick();
      guard++;
    end
    check("iordy_done_cycle", done_cyc - acc_cyc, 11);
    check("iordy_pulses", pulses, 1);
    check("iordy_rvalid_rel", first_rv_rel, 10);
    check("iordy_queue_drained", rd_q.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
